// File: rtl/pico_sample_feeder.sv
// pico_sample_feeder
//   Producer side of the PicoBlaze sample-input interface. Signed 16-bit audio
//   samples are converted to an 8-bit magnitude byte and buffered in a small
//   FIFO. Each byte is offered on a stable data_out with a single-cycle
//   data_ready pulse (the interrupt request). The next byte is offered only
//   after data_ack and a minimum idle gap. An unacknowledged byte is re-pulsed
//   after ACK_TIMEOUT cycles.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   sample_in      signed audio sample (two's complement)
//   sample_valid   sample_in valid this cycle
//   sample_ready   FIFO not full (from registered count)
//   data_out       magnitude byte presented to the processor
//   data_ready     one-cycle pulse marking a (re)presented byte
//   data_ack       interrupt acknowledge, any-cycle pulse
//   overflow_count samples dropped while full, saturating
//   retry_count    timeout re-pulses issued, saturating
//   busy           FSM not idle or FIFO not empty
module pico_sample_feeder #(
    parameter int DEPTH       = 8,
    parameter int MIN_GAP     = 4,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [7:0]  data_out,
    output logic        data_ready,
    input  logic        data_ack,
    output logic [7:0]  overflow_count,
    output logic [7:0]  retry_count,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    localparam logic [TW-1:0] T_LAST     = TW'(ACK_TIMEOUT - 1);
    localparam logic [GW-1:0] G_LAST     = GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PRESENT  = 2'd1;
    localparam logic [1:0] S_WAIT_ACK = 2'd2;
    localparam logic [1:0] S_GAP      = 2'd3;

    // With no gap configured, acknowledgement returns straight to IDLE.
    localparam logic [1:0] S_AFTER_ACK = (MIN_GAP == 0) ? S_IDLE : S_GAP;

    logic [1:0]    state;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gcnt;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;

    logic [14:0]   mag;
    logic [7:0]    mag_byte;
    logic          push;
    logic          pop;

    // Magnitude: only bits [14:0] matter once 0x8000 is saturated separately,
    // so the negation is done at 15 bits.
    always_comb begin
        if (sample_in == 16'h8000) begin
            mag = 15'h7FFF;
        end else if (sample_in[15]) begin
            mag = 15'd0 - sample_in[14:0];
        end else begin
            mag = sample_in[14:0];
        end
    end

    assign mag_byte = 8'(mag >> 7);

    assign sample_ready = (count != FULL_COUNT);
    assign push         = sample_valid && sample_ready;
    assign pop          = (state == S_IDLE) && (count != '0);
    assign data_ready   = (state == S_PRESENT);
    assign busy         = (state != S_IDLE) || (count != '0);

    // Storage is not reset; resetting the pointers and count discards it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= mag_byte;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            overflow_count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (sample_valid && !sample_ready && (overflow_count != 8'hFF)) begin
                overflow_count <= overflow_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            data_out    <= '0;
            tcnt        <= '0;
            gcnt        <= '0;
            retry_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        data_out <= mem[rptr];
                        state    <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    tcnt <= '0;
                    // An ack coincident with the pulse already counts.
                    if (data_ack) begin
                        gcnt  <= '0;
                        state <= S_AFTER_ACK;
                    end else begin
                        state <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (data_ack) begin
                        gcnt  <= '0;
                        state <= S_AFTER_ACK;
                    end else if (tcnt == T_LAST) begin
                        if (retry_count != 8'hFF) begin
                            retry_count <= retry_count + 8'd1;
                        end
                        state <= S_PRESENT;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_GAP: begin
                    if (gcnt == G_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pico_sample_feeder.sv
// Self-checking bench for pico_sample_feeder (DEPTH=8, MIN_GAP=4,
// ACK_TIMEOUT=16). Table of {sample, expected byte} records plus directed
// sequences for backpressure, timeout re-pulse, early ack and async reset.
module tb_pico_sample_feeder;

    localparam int DEPTH       = 8;
    localparam int MIN_GAP     = 4;
    localparam int ACK_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  data_out;
    logic        data_ready;
    logic        data_ack;
    logic [7:0]  overflow_count;
    logic [7:0]  retry_count;
    logic        busy;

    pico_sample_feeder #(
        .DEPTH       (DEPTH),
        .MIN_GAP     (MIN_GAP),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .data_ack       (data_ack),
        .overflow_count (overflow_count),
        .retry_count    (retry_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sample;
        logic [7:0]  mag;
    } vec_t;

    vec_t vecs [8];

    int n_checks  = 0;
    int n_pass    = 0;
    int dbl_pulse = 0;
    logic prev_ready = 1'b0;

    // data_ready must never be high on two consecutive cycles.
    always @(posedge clk) begin
        #1;
        if (data_ready && prev_ready) dbl_pulse++;
        prev_ready = data_ready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] s);
        sample_in    = s;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic ack_tick();
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
    endtask

    task automatic settle();
        repeat (MIN_GAP + 2) tick();
    endtask

    task automatic wait_pulse(input string name, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!data_ready && n < max);
        check(name, data_ready, 1'b1);
    endtask

    initial begin
        int n;
        int pulses;

        vecs[0] = '{16'h1234, 8'h24};
        vecs[1] = '{16'hFF00, 8'h02};
        vecs[2] = '{16'h8000, 8'hFF};
        vecs[3] = '{16'h0000, 8'h00};
        vecs[4] = '{16'h7FFF, 8'hFF};
        vecs[5] = '{16'hFFFF, 8'h00};
        vecs[6] = '{16'hFF80, 8'h01};
        vecs[7] = '{16'h3FFF, 8'h7F};

        reset_n      = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        data_ack     = 1'b0;
        #3;
        check("rst_data_out", data_out, 8'h00);
        check("rst_data_ready", data_ready, 1'b0);
        check("rst_overflow", overflow_count, 8'h00);
        check("rst_retry", retry_count, 8'h00);
        check("rst_sample_ready", sample_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        #20;
        reset_n = 1'b1;
        tick();

        // Single byte, latency, pulse width, and post-ack spacing.
        push(16'h1234);
        check("t1_no_pulse_yet", data_ready, 1'b0);
        check("t1_busy", busy, 1'b1);
        tick();
        check("t1_pulse", data_ready, 1'b1);
        check("t1_byte", data_out, 8'h24);
        push(16'h0400);
        check("t1_pulse_one_cycle", data_ready, 1'b0);
        tick();
        check("t1_byte_held", data_out, 8'h24);
        ack_tick();
        wait_pulse("t1_next_pulse", 20, n);
        check("t1_spacing", n + 1, 2 + MIN_GAP);
        check("t1_next_byte", data_out, 8'h08);
        ack_tick();
        settle();
        check("t1_idle", busy, 1'b0);

        // Conversion table, each byte stable until its ack.
        for (int i = 0; i < 8; i++) push(vecs[i].sample);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                wait_pulse("t2_pulse", 20, n);
                check("t2_spacing", n + 1, 2 + MIN_GAP);
            end
            check("t2_byte", data_out, vecs[i].mag);
            tick();
            tick();
            check("t2_stable", data_out, vecs[i].mag);
            ack_tick();
        end
        settle();
        check("t2_idle", busy, 1'b0);

        // Backpressure: 10 consecutive samples, one dropped.
        for (int i = 1; i <= 10; i++) begin
            sample_in    = 16'(i << 7);
            sample_valid = 1'b1;
            tick();
            if (i == 8) check("t3_ready_before_full", sample_ready, 1'b1);
            if (i == 9) check("t3_full", sample_ready, 1'b0);
        end
        sample_valid = 1'b0;
        check("t3_overflow", overflow_count, 8'd1);
        check("t3_first_byte", data_out, 8'd1);
        for (int i = 2; i <= 9; i++) begin
            ack_tick();
            wait_pulse("t3_pulse", 20, n);
            check("t3_byte_order", data_out, 8'(i));
        end
        ack_tick();
        settle();
        check("t3_drained", busy, 1'b0);
        check("t3_ready_again", sample_ready, 1'b1);

        // Ack timeout re-pulses.
        push(16'h2000);
        wait_pulse("t4_first", 10, n);
        check("t4_first_byte", data_out, 8'h40);
        push(16'h0100);
        wait_pulse("t4_repulse1", 40, n);
        check("t4_period1", n + 1, ACK_TIMEOUT + 1);
        check("t4_same_byte1", data_out, 8'h40);
        check("t4_retry1", retry_count, 8'd1);
        wait_pulse("t4_repulse2", 40, n);
        check("t4_period2", n, ACK_TIMEOUT + 1);
        check("t4_retry2", retry_count, 8'd2);
        tick();
        ack_tick();
        wait_pulse("t4_next", 20, n);
        check("t4_next_byte", data_out, 8'h02);
        check("t4_retry_kept", retry_count, 8'd2);
        ack_tick();
        settle();

        // Ack coincident with data_ready.
        push(16'h0C00);
        wait_pulse("t5_pulse", 10, n);
        check("t5_byte", data_out, 8'h18);
        ack_tick();
        check("t5_in_gap", busy, 1'b1);
        pulses = 0;
        repeat (30) begin
            tick();
            if (data_ready) pulses++;
        end
        check("t5_no_repulse", pulses, 0);
        check("t5_retry_unchanged", retry_count, 8'd2);
        check("t5_idle", busy, 1'b0);

        // Asynchronous reset with bytes queued.
        for (int i = 0; i < 6; i++) push(16'((i + 32) << 7));
        check("t6_presenting", data_out, 8'h20);
        check("t6_busy", busy, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check("t6_rst_ready", data_ready, 1'b0);
        check("t6_rst_data_out", data_out, 8'h00);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_retry", retry_count, 8'h00);
        check("t6_rst_overflow", overflow_count, 8'h00);
        #20;
        reset_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            tick();
            if (data_ready) pulses++;
        end
        check("t6_no_pulse", pulses, 0);
        check("t6_still_idle", busy, 1'b0);
        push(16'h0A00);
        tick();
        check("t6_new_pulse", data_ready, 1'b1);
        check("t6_new_byte", data_out, 8'h14);
        ack_tick();
        settle();

        check("no_double_pulse", dbl_pulse, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
